// File: rtl/dmem_bus_ctrl.sv
// M-stage data-memory bus controller: posted one-entry store buffer, blocking
// loads with a read-latency watchdog, and sticky misalign/bus-error flags.
module dmem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] ERRDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwriteM,
  input  logic        memreadM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        misalignM,
  output logic        buserrM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;

  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_mis;
  logic        r_err;
  logic [7:0]  r_cnt;

  logic        w_aligned;
  logic        w_store;
  logic        w_load;
  logic        w_cnt_last;
  logic        w_stall;
  logic        w_issue_wr;
  logic        w_issue_rd;
  logic        w_gnt_done;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_capture;
  logic        w_timeout;
  logic        w_mis;
  logic        w_mis_load;

  // A dual strobe is a store; the load half is ignored.
  assign w_aligned  = (aluoutM[1:0] == 2'b00);
  assign w_store    = memwriteM;
  assign w_load     = memreadM & ~memwriteM;
  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_stall    = 1'b0;
    w_issue_wr = 1'b0;
    w_issue_rd = 1'b0;
    w_gnt_done = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_capture  = 1'b0;
    w_timeout  = 1'b0;
    w_mis      = 1'b0;
    w_mis_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_store) begin
          if (w_aligned) begin
            w_issue_wr = 1'b1;
            w_next     = WR_REQ;
          end else begin
            w_mis = 1'b1;
          end
        end else if (w_load) begin
          if (w_aligned) begin
            w_stall    = 1'b1;
            w_issue_rd = 1'b1;
            w_next     = RD_REQ;
          end else begin
            w_mis      = 1'b1;
            w_mis_load = 1'b1;
          end
        end
      end
      WR_REQ: begin
        // Any new access waits until the buffered write drains, keeping order.
        w_stall = memwriteM | memreadM;
        if (bus_gnt) begin
          w_gnt_done = 1'b1;
          w_next     = IDLE;
        end
      end
      RD_REQ: begin
        w_stall = 1'b1;
        if (bus_gnt) begin
          w_gnt_done = 1'b1;
          w_cnt_clr  = 1'b1;
          w_next     = RD_WAIT;
        end
      end
      RD_WAIT: begin
        w_stall = 1'b1;
        if (bus_rvalid) begin
          w_capture = 1'b1;
          w_next    = DONE;
        end else if (w_cnt_last) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_issue_wr) begin
        r_req   <= 1'b1;
        r_we    <= 1'b1;
        r_addr  <= {aluoutM[31:2], 2'b00};
        r_wdata <= writedataM;
      end else if (w_issue_rd) begin
        r_req  <= 1'b1;
        r_we   <= 1'b0;
        r_addr <= {aluoutM[31:2], 2'b00};
      end else if (w_gnt_done) begin
        r_req <= 1'b0;
      end

      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_capture) begin
        r_rdata <= bus_rdata;
      end else if (w_timeout) begin
        r_rdata <= ERRDATA;
      end else if (w_mis_load) begin
        r_rdata <= '0;
      end

      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_mis) begin
        r_mis <= 1'b1;
      end
    end
  end

  // Gating with reset keeps the stall low while reset is asserted.
  assign stallM    = w_stall & ~reset;
  assign readdataM = r_rdata;
  assign misalignM = r_mis;
  assign buserrM   = r_err;
  assign bus_req   = r_req;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed table-driven bench for dmem_bus_ctrl, plus hand-written reset sequences.
module tb_dmem_bus_ctrl;

  logic        clk;
  logic        reset;
  logic        memwriteM;
  logic        memreadM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        misalignM;
  logic        buserrM;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int unsigned n_pass;
  int unsigned n_total;

  typedef struct {
    logic        we;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        gnt;
    logic        rv;
    logic [31:0] rdi;
    logic        e_stall;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic        e_mis;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  dmem_bus_ctrl #(.TIMEOUT(4), .ERRDATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .memwriteM(memwriteM), .memreadM(memreadM),
    .aluoutM(aluoutM), .writedataM(writedataM),
    .readdataM(readdataM), .stallM(stallM),
    .misalignM(misalignM), .buserrM(buserrM),
    .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic we, input logic rd, input logic [31:0] addr,
                     input logic [31:0] wd, input logic gnt, input logic rv,
                     input logic [31:0] rdi, input logic e_stall, input logic e_req,
                     input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wd,
                     input logic [31:0] e_rd, input logic e_mis, input logic e_err);
    vec_t v;
    v.we = we; v.rd = rd; v.addr = addr; v.wd = wd; v.gnt = gnt; v.rv = rv; v.rdi = rdi;
    v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr;
    v.e_wd = e_wd; v.e_rd = e_rd; v.e_mis = e_mis; v.e_err = e_err;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    memwriteM  = v.we;
    memreadM   = v.rd;
    aluoutM    = v.addr;
    writedataM = v.wd;
    bus_gnt    = v.gnt;
    bus_rvalid = v.rv;
    bus_rdata  = v.rdi;
    #1;
    chk({tag, " stallM"},    {31'd0, stallM},    {31'd0, v.e_stall});
    chk({tag, " bus_req"},   {31'd0, bus_req},   {31'd0, v.e_req});
    chk({tag, " bus_we"},    {31'd0, bus_we},    {31'd0, v.e_we});
    chk({tag, " bus_addr"},  bus_addr,           v.e_addr);
    chk({tag, " bus_wdata"}, bus_wdata,          v.e_wd);
    chk({tag, " readdataM"}, readdataM,          v.e_rd);
    chk({tag, " misalignM"}, {31'd0, misalignM}, {31'd0, v.e_mis});
    chk({tag, " buserrM"},   {31'd0, buserrM},   {31'd0, v.e_err});
  endtask

  task automatic idle_inputs();
    memwriteM = 1'b0; memreadM = 1'b0; aluoutM = '0; writedataM = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stallM"},    {31'd0, stallM},    32'd0);
    chk({tag, " bus_req"},   {31'd0, bus_req},   32'd0);
    chk({tag, " bus_we"},    {31'd0, bus_we},    32'd0);
    chk({tag, " bus_addr"},  bus_addr,           32'd0);
    chk({tag, " bus_wdata"}, bus_wdata,          32'd0);
    chk({tag, " readdataM"}, readdataM,          32'd0);
    chk({tag, " misalignM"}, {31'd0, misalignM}, 32'd0);
    chk({tag, " buserrM"},   {31'd0, buserrM},   32'd0);
  endtask

  initial begin
    vec_t h[$];
    n_pass = 0;
    n_total = 0;
    idle_inputs();
    reset = 1'b1;
    // Reset state, with a load strobe present: stall must still be low.
    memreadM = 1'b1; aluoutM = 32'h40;
    #2;
    chk_all_zero("reset");
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;

    //   we rd addr   wdata         gnt rv rdata         st rq bwe addr   wdata         rdata         mis err
    // load 0x40, immediate grant and valid
    add(0, 1, 32'h40, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h00, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h40, 32'h0,        1, 0, 32'h0,        1, 1, 0, 32'h40, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h40, 32'h0,        0, 1, 32'h12345678, 1, 0, 0, 32'h40, 32'h0,        32'h0,        0, 0);
    add(0, 1, 32'h40, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h40, 32'h0,        32'h12345678, 0, 0);
    add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h40, 32'h0,        32'h12345678, 0, 0);
    // posted store to 0x44, then load 0x44 behind it with grant 2 cycles late
    add(1, 0, 32'h44, 32'hCAFEF00D, 0, 0, 32'h0,        0, 0, 0, 32'h40, 32'h0,        32'h12345678, 0, 0);
    add(0, 1, 32'h44, 32'h0,        0, 0, 32'h0,        1, 1, 1, 32'h44, 32'hCAFEF00D, 32'h12345678, 0, 0);
    add(0, 1, 32'h44, 32'h0,        0, 0, 32'h0,        1, 1, 1, 32'h44, 32'hCAFEF00D, 32'h12345678, 0, 0);
    add(0, 1, 32'h44, 32'h0,        1, 0, 32'h0,        1, 1, 1, 32'h44, 32'hCAFEF00D, 32'h12345678, 0, 0);
    add(0, 1, 32'h44, 32'h0,        0, 0, 32'h0,        1, 0, 1, 32'h44, 32'hCAFEF00D, 32'h12345678, 0, 0);
    add(0, 1, 32'h44, 32'h0,        1, 0, 32'h0,        1, 1, 0, 32'h44, 32'hCAFEF00D, 32'h12345678, 0, 0);
    add(0, 1, 32'h44, 32'h0,        0, 1, 32'hCAFEF00D, 1, 0, 0, 32'h44, 32'hCAFEF00D, 32'h12345678, 0, 0);
    add(0, 1, 32'h44, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h44, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h44, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    // timeout (TIMEOUT=4): granted, never valid
    add(0, 1, 32'h60, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h44, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    add(0, 1, 32'h60, 32'h0,        1, 0, 32'h0,        1, 1, 0, 32'h60, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    add(0, 1, 32'h60, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h60, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    add(0, 1, 32'h60, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h60, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    add(0, 1, 32'h60, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h60, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    add(0, 1, 32'h60, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h60, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    add(0, 1, 32'h60, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h60, 32'hCAFEF00D, 32'hDEADBEEF, 0, 1);
    // late rvalid in IDLE is ignored
    add(0, 0, 32'h0,  32'h0,        0, 1, 32'h11111111, 0, 0, 0, 32'h60, 32'hCAFEF00D, 32'hDEADBEEF, 0, 1);
    add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h60, 32'hCAFEF00D, 32'hDEADBEEF, 0, 1);
    // misaligned load 0x41, then misaligned store 0x42
    add(0, 1, 32'h41, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h60, 32'hCAFEF00D, 32'hDEADBEEF, 0, 1);
    add(1, 0, 32'h42, 32'h55555555, 0, 0, 32'h0,        0, 0, 0, 32'h60, 32'hCAFEF00D, 32'h0,        1, 1);
    add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h60, 32'hCAFEF00D, 32'h0,        1, 1);
    // dual strobe at 0x50: single write, no stall
    add(1, 1, 32'h50, 32'hA5A5A5A5, 0, 0, 32'h0,        0, 0, 0, 32'h60, 32'hCAFEF00D, 32'h0,        1, 1);
    add(0, 0, 32'h0,  32'h0,        1, 0, 32'h0,        0, 1, 1, 32'h50, 32'hA5A5A5A5, 32'h0,        1, 1);
    add(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 0, 1, 32'h50, 32'hA5A5A5A5, 32'h0,        1, 1);

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset asserted mid-cycle while in RD_WAIT with the load still held.
    add(0, 1, 32'h80, 32'h0,        0, 0, 32'h0,        1, 0, 1, 32'h50, 32'hA5A5A5A5, 32'h0,        1, 1);
    add(0, 1, 32'h80, 32'h0,        1, 0, 32'h0,        1, 1, 0, 32'h80, 32'hA5A5A5A5, 32'h0,        1, 1);
    add(0, 1, 32'h80, 32'h0,        0, 0, 32'h0,        1, 0, 0, 32'h80, 32'hA5A5A5A5, 32'h0,        1, 1);
    for (int unsigned i = tbl.size() - 3; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("rw%0d", i));
    end
    #1 reset = 1'b1;
    #1;
    chk_all_zero("rst_rdwait");
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;

    // Normal load afterwards, then reset during RD_REQ drops bus_req at once.
    h.delete();
    tbl.delete();
    add(0, 1, 32'h84, 32'h0, 0, 0, 32'h0,        1, 0, 0, 32'h00, 32'h0, 32'h0,        0, 0);
    add(0, 1, 32'h84, 32'h0, 1, 0, 32'h0,        1, 1, 0, 32'h84, 32'h0, 32'h0,        0, 0);
    add(0, 1, 32'h84, 32'h0, 0, 1, 32'h87654321, 1, 0, 0, 32'h84, 32'h0, 32'h0,        0, 0);
    add(0, 1, 32'h84, 32'h0, 0, 0, 32'h0,        0, 0, 0, 32'h84, 32'h0, 32'h87654321, 0, 0);
    add(0, 1, 32'h88, 32'h0, 0, 0, 32'h0,        1, 0, 0, 32'h84, 32'h0, 32'h87654321, 0, 0);
    add(0, 1, 32'h88, 32'h0, 0, 0, 32'h0,        1, 1, 0, 32'h88, 32'h0, 32'h87654321, 0, 0);
    foreach (tbl[i]) h.push_back(tbl[i]);
    for (int unsigned i = 0; i < h.size(); i++) begin
      apply(h[i], $sformatf("post%0d", i));
    end
    #1 reset = 1'b1;
    #1;
    chk_all_zero("rst_rdreq");
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

endmodule

// File: doc/dmem_bus_ctrl.md
# dmem_bus_ctrl

Memory-stage bus controller between the pipelined MIPS core's M stage and an external word-addressed data bus with request/grant and read-valid handshakes. It turns the core's `aluoutM`/`writedataM`/`memwriteM` and load strobe into bus transactions. Stores are posted through a one-entry write buffer, and loads block. `stallM` freezes the pipeline while a load is in flight or the write buffer is busy, and a watchdog bounds read latency.

## Interface
- `TIMEOUT`, 16: max cycles waited in RD_WAIT for `bus_rvalid`; must be 1..255.
- `ERRDATA`, 32'hDEADBEEF: data returned for a timed-out load.

- `clk`  in  1  sole clock; all state on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `memwriteM`  in  1  M-stage store.
- `memreadM`  in  1  M-stage load (the core's `memtoregM`).
- `aluoutM`  in  32  byte address.
- `writedataM`  in  32  store data.
- `readdataM`  out  32  load data; registered.
- `stallM`  out  1  combinational; core holds F/D/E/M and all M-stage inputs while high.
- `misalignM`  out  1  sticky: access with `aluoutM[1:0]!=0` seen.
- `buserrM`  out  1  sticky: load timed out.
- `bus_req`  out  1  transaction request; registered.
- `bus_we`  out  1  1 = write; registered.
- `bus_addr`  out  32  word-aligned byte address; registered.
- `bus_wdata`  out  32  write data; registered.
- `bus_gnt`  in  1  request accepted this cycle.
- `bus_rvalid`  in  1  read data valid; ≥1 cycle after read grant.
- `bus_rdata`  in  32  read data.

## Operation
- FSM states are IDLE, WR_REQ, RD_REQ, RD_WAIT and DONE.
- **IDLE, store, aligned:** latch addr/data into `bus_addr`/`bus_wdata`, set `bus_we=1` and `bus_req=1`, then go to WR_REQ. `stallM=0` because the store is posted.
- **IDLE, load, aligned:** `stallM=1`. Latch the address and set `bus_we=0` and `bus_req=1`, then go to RD_REQ.
- **WR_REQ:** hold `bus_req` until `bus_gnt`, then drop `bus_req` and return to IDLE. A new load or store seen here gives `stallM=1` and is serviced from IDLE on the next cycle. No access is lost and order is preserved.
- **RD_REQ:** hold the request until `bus_gnt`, then drop `bus_req`, clear the timeout counter and go to RD_WAIT.
- **RD_WAIT:**
  - On `bus_rvalid`, capture `bus_rdata` into `readdataM` and go to DONE.
  - Without it, increment the counter. When the counter reaches `TIMEOUT-1` with no `rvalid`, load `ERRDATA` into `readdataM`, set `buserrM` and go to DONE.
- **DONE:** `stallM=0` so the core consumes `readdataM`. The still-present load is not reissued. Next state is IDLE.
- **Misaligned access in IDLE:** no bus transaction and `misalignM` is set. A load gives `readdataM=0` with no stall. A store is dropped.
- **`memreadM` and `memwriteM` both high:** treated as a store and the load is ignored.
- **`bus_rvalid` outside RD_WAIT** (for example a late response after timeout) is ignored.
- **`readdataM`** holds its last value outside DONE.
- **Counter:** 8-bit, saturating.

## Timing
- Reset values: state IDLE, counter 0, and these outputs all 0: `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `readdataM`, `misalignM`, `buserrM`, `stallM`.
- **Store latency:** 0 stall cycles. The bus request appears the cycle after the store is seen in IDLE.
- **Load with `bus_gnt` in the first RD_REQ cycle and `bus_rvalid` in the first RD_WAIT cycle:** stall in IDLE, RD_REQ and RD_WAIT, so 3 stall cycles. Data is valid and `stallM=0` in DONE.
- **Each extra grant or valid wait cycle** adds 1 stall cycle.
- **Timed-out load:** stall cycles = 2 + grant wait + `TIMEOUT`.
- **Load behind a pending write:** stall also covers the WR_REQ cycles.
- **Reset mid-transaction:** `bus_req` drops asynchronously and the transaction is abandoned. The bus must tolerate this.
- **Sticky flags** clear only on reset.

## Test plan
- **Load, immediate grant:** load at 0x40, `bus_gnt` in the first RD_REQ cycle, `bus_rvalid` one cycle later with 0x12345678. Required: exactly 3 stall cycles, then `readdataM=0x12345678` with `stallM=0`, one bus request only.
- **Posted store then load:** store 0xCAFEF00D to 0x44, then the next cycle a load from 0x44, with the grant delayed 2 cycles. Required: the store has no stall; the load stalls until the write is granted, then issues its read; `bus_we` sequence is 1 then 0.
- **Timeout:** `TIMEOUT=4`, read granted, never valid. Required: `readdataM=0xDEADBEEF` and `buserrM=1` after 4 RD_WAIT cycles. A late `bus_rvalid` in IDLE leaves `readdataM` unchanged.
- **Misaligned:** load at 0x41 gives no `bus_req`, `stallM=0`, `readdataM=0`, `misalignM=1`. A store at 0x42 gives no `bus_req` and `misalignM` stays 1.
- **Dual strobe:** `memreadM` and `memwriteM` both high at 0x50. Required: a single write transaction and no stall.
- **Reset during RD_WAIT:** `bus_req` and `stallM` are 0 in the same cycle, all outputs are 0, and the next load proceeds normally.
